// File: rtl/reader_pkg.sv
// reader_pkg: shared defaults and FSM state encoding for the Reader scheduler.
package reader_pkg;
    localparam int DEF_NCH = 4;
    localparam int DEF_DW  = 12;
    localparam int DEF_CW  = 20;
    localparam int DEF_TMO = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT_ACC,
        S_WAIT_DONE,
        S_GAP
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from i_ptr + 1 with wrap.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [IW-1:0]  i_ptr,
    output logic [NCH-1:0] o_grant,
    output logic [IW-1:0]  o_idx
);
    logic          w_found;
    logic [IW-1:0] w_c;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_c     = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_c = IW'((int'(i_ptr) + k) % NCH);
            if (!w_found && i_req[w_c]) begin
                w_found    = 1'b1;
                o_grant[w_c] = 1'b1;
                o_idx      = w_c;
            end
        end
    end
endmodule

// File: rtl/reader_sched.sv
// reader_sched: round-robin sample scheduler feeding one Reader, with start timeout and inter-job gap.
module reader_sched
    import reader_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int DW  = DEF_DW,
    parameter int CW  = DEF_CW,
    parameter int TMO = DEF_TMO
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          i_req,
    input  logic [NCH*DW-1:0]       i_ch_data,
    input  logic [CW-1:0]           i_period,
    input  logic                    i_rd_ready,
    output logic [NCH-1:0]          o_ack,
    output logic                    o_rd_start,
    output logic [DW-1:0]           o_rd_data,
    output logic [CW-1:0]           o_rd_counter,
    output logic [$clog2(NCH)-1:0]  o_rd_ch,
    output logic                    o_busy,
    output logic                    o_err
);
    localparam int IW = $clog2(NCH);
    localparam int TW = $clog2(TMO + 1);

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [TW-1:0]   r_tmo;
    logic [CW-1:0]   r_gap;
    logic [NCH-1:0]  r_ack;
    logic            r_rd_start;
    logic [DW-1:0]   r_rd_data;
    logic [CW-1:0]   r_rd_counter;
    logic [IW-1:0]   r_rd_ch;
    logic            r_err;
    logic [NCH-1:0]  w_grant;
    logic [IW-1:0]   w_idx;
    logic            w_gap_done;

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // The gap uses the period latched at grant, so mid-job period changes wait for the next job.
    assign w_gap_done = (&r_gap) || (r_gap + CW'(1) >= r_rd_counter);

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= IW'(NCH - 1);
            r_tmo        <= '0;
            r_gap        <= '0;
            r_ack        <= '0;
            r_rd_start   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_counter <= '0;
            r_rd_ch      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_rd_start <= 1'b0;
            case (r_state)
                S_IDLE: if (|i_req && i_rd_ready) begin
                    r_ack        <= w_grant;
                    r_rd_data    <= i_ch_data[w_idx*DW +: DW];
                    r_rd_ch      <= w_idx;
                    r_rd_counter <= i_period;
                    r_ptr        <= w_idx;
                    r_state      <= S_GRANT;
                end
                S_GRANT: begin
                    r_rd_start <= 1'b1;
                    r_state    <= S_START;
                end
                S_START: begin
                    r_tmo   <= TW'(1);
                    r_state <= S_WAIT_ACC;
                end
                S_WAIT_ACC: if (!i_rd_ready) begin
                    r_state <= S_WAIT_DONE;
                end else if (r_tmo == TW'(TMO - 1)) begin
                    r_err   <= 1'b1;
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
                S_WAIT_DONE: if (i_rd_ready) begin
                    r_gap   <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: if (w_gap_done) r_state <= S_IDLE;
                       else r_gap <= r_gap + CW'(1);
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ack        = r_ack;
    assign o_rd_start   = r_rd_start;
    assign o_rd_data    = r_rd_data;
    assign o_rd_counter = r_rd_counter;
    assign o_rd_ch      = r_rd_ch;
    assign o_busy       = (r_state != S_IDLE);
    assign o_err        = r_err;
endmodule
